// File: rtl/muldiv_seq_pkg.sv
// Shared types and decode helpers for the RV32M multiply/divide unit.
// Maps M-extension funct3 codes to the operand-signedness and result-selection controls.
package muldiv_seq_pkg;

  localparam logic [2:0] FNC_MUL    = 3'b000;
  localparam logic [2:0] FNC_MULH   = 3'b001;
  localparam logic [2:0] FNC_MULHSU = 3'b010;
  localparam logic [2:0] FNC_MULHU  = 3'b011;
  localparam logic [2:0] FNC_DIV    = 3'b100;
  localparam logic [2:0] FNC_DIVU   = 3'b101;
  localparam logic [2:0] FNC_REM    = 3'b110;
  localparam logic [2:0] FNC_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic a_signed;
    logic b_signed;
    logic is_div;
    logic sel_rem;  // divide: return remainder instead of quotient
    logic sel_hi;   // multiply: return upper word of the product
  } op_t;

  function automatic op_t decode(input logic [2:0] f);
    op_t d;
    d = '0;
    case (f)
      FNC_MUL:    ;
      FNC_MULH:   begin d.a_signed = 1'b1; d.b_signed = 1'b1; d.sel_hi = 1'b1; end
      FNC_MULHSU: begin d.a_signed = 1'b1; d.sel_hi = 1'b1; end
      FNC_MULHU:  d.sel_hi = 1'b1;
      FNC_DIV:    begin d.a_signed = 1'b1; d.b_signed = 1'b1; d.is_div = 1'b1; end
      FNC_DIVU:   d.is_div = 1'b1;
      FNC_REM:    begin d.a_signed = 1'b1; d.b_signed = 1'b1; d.is_div = 1'b1; d.sel_rem = 1'b1; end
      FNC_REMU:   begin d.is_div = 1'b1; d.sel_rem = 1'b1; end
      default:    ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// EX-stage request/response bundle for the multiply/divide unit.
interface muldiv_seq_if #(
  parameter int DWIDTH = 32
);
  logic              start;
  logic [2:0]        func;
  logic [DWIDTH-1:0] op_a;
  logic [DWIDTH-1:0] op_b;
  logic              flush;
  logic              stall;
  logic              busy;
  logic              done;
  logic [DWIDTH-1:0] result;

  modport master (
    output start, func, op_a, op_b, flush,
    input  stall, busy, done, result
  );

  modport slave (
    input  start, func, op_a, op_b, flush,
    output stall, busy, done, result
  );
endinterface

// File: rtl/muldiv_dp.sv
// Multiply/divide datapath: operand magnitudes, shift-add / restoring-divide step,
// sign correction of the final word, and the divide special-case results.
module muldiv_dp
  import muldiv_seq_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [2:0]        func,
  input  logic [DWIDTH-1:0] op_a,
  input  logic [DWIDTH-1:0] op_b,
  output logic              fast,
  output logic [DWIDTH-1:0] fast_result,
  output logic [DWIDTH-1:0] final_result
);

  localparam int W = DWIDTH;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  op_t            dec;
  logic           sa, sb, b_zero, ovf, ge;
  logic [W-1:0]   mag_a, mag_b;
  logic           is_div_q, sel_rem_q, sel_hi_q, neg_q;
  logic [2*W-1:0] acc, acc_n, prod_fix;
  logic [W-1:0]   rem, rem_n, opnd_b, quo_fix, rem_fix;
  logic [W:0]     mul_sum, shifted;

  assign dec = decode(func);
  assign sa  = dec.a_signed & op_a[W-1];
  assign sb  = dec.b_signed & op_b[W-1];
  // Negating 0x80000000 yields 0x80000000, which read unsigned is the correct 2^31 magnitude.
  assign mag_a = sa ? -op_a : op_a;
  assign mag_b = sb ? -op_b : op_b;

  assign b_zero = (op_b == '0);
  assign ovf    = dec.is_div && dec.b_signed && (op_a == MIN_NEG) && (op_b == '1);
  assign fast   = dec.is_div && (b_zero || ovf);
  assign fast_result = b_zero ? (dec.sel_rem ? op_a : '1)
                              : (dec.sel_rem ? '0 : MIN_NEG);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_div_q  <= 1'b0;
      sel_rem_q <= 1'b0;
      sel_hi_q  <= 1'b0;
      neg_q     <= 1'b0;
      acc       <= '0;
      rem       <= '0;
      opnd_b    <= '0;
    end else if (load) begin
      is_div_q  <= dec.is_div;
      sel_rem_q <= dec.sel_rem;
      sel_hi_q  <= dec.sel_hi;
      neg_q     <= dec.sel_rem ? sa : (sa ^ sb);
      acc       <= {{W{1'b0}}, mag_a};
      rem       <= '0;
      opnd_b    <= mag_b;
    end else if (step) begin
      acc <= acc_n;
      rem <= rem_n;
    end
  end

  // One iteration. Multiply keeps the multiplier in acc[W-1:0] and shifts the product in from the top;
  // divide shifts the dividend out of acc[W-1:0] and the quotient bits in behind it.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd_b} : '0);
    shifted = {rem, acc[W-1]};
    ge      = (shifted >= {1'b0, opnd_b});
    acc_n   = {mul_sum, acc[W-1:1]};
    rem_n   = rem;
    if (is_div_q) begin
      acc_n = {acc[2*W-1:W], acc[W-2:0], ge};
      // After a successful subtract the remainder is below the divisor, so the low W bits are exact.
      rem_n = shifted[W-1:0] - (ge ? opnd_b : '0);
    end
  end

  // Sign fix on the full-width values before any word is selected.
  always_comb begin
    prod_fix = neg_q ? -acc_n : acc_n;
    quo_fix  = neg_q ? -acc_n[W-1:0] : acc_n[W-1:0];
    rem_fix  = neg_q ? -rem_n : rem_n;
    if (is_div_q) final_result = sel_rem_q ? rem_fix : quo_fix;
    else          final_result = sel_hi_q ? prod_fix[2*W-1:W] : prod_fix[W-1:0];
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide unit: FSM and iteration counter around muldiv_dp.
// Stalls the front of the pipe while iterating and presents a registered result with a done pulse.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  muldiv_seq_if.slave bus
);

  localparam int CW = $clog2(DWIDTH);

  state_e            state, state_n;
  logic [CW-1:0]     count;
  logic              accept, fast, last, busy_q, done_q;
  logic [DWIDTH-1:0] result_q, fast_result, final_result;

  // DONE accepts a new request so back-to-back operations run without a bubble; flush beats start.
  assign accept = bus.start && !bus.flush && (state != RUN);
  assign last   = (state == RUN) && (count == CW'(DWIDTH - 1));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = fast ? DONE : RUN;
      RUN:     if (bus.flush) state_n = IDLE;
               else if (last) state_n = DONE;
      DONE:    if (accept) state_n = fast ? DONE : RUN;
               else state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state  <= state_n;
      busy_q <= (state_n == RUN);
      done_q <= (state_n == DONE);
      if (accept)              count <= '0;
      else if (state == RUN)   count <= count + CW'(1);
      if (accept && fast)      result_q <= fast_result;
      else if (last && !bus.flush) result_q <= final_result;
    end
  end

  muldiv_dp #(.DWIDTH(DWIDTH)) u_dp (
    .clk          (clk),
    .rst          (rst),
    .load         (accept),
    .step         (state == RUN),
    .func         (bus.func),
    .op_a         (bus.op_a),
    .op_b         (bus.op_b),
    .fast         (fast),
    .fast_result  (fast_result),
    .final_result (final_result)
  );

  // A fast-path accept does not stall: the pipeline waits on the one-cycle DONE instead.
  assign bus.stall  = (accept && !fast) || (state == RUN);
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: arithmetic, latency, fast paths, flush and async reset.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [31:0] last_res;

  muldiv_seq_if #(.DWIDTH(32)) bus ();

  muldiv_seq #(.DWIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.func  = f;
    bus.op_a  = a;
    bus.op_b  = b;
    #1;
  endtask

  // Crosses the accept edge and leaves the bench at the falling edge of cycle N+1.
  task automatic accept_edge();
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Entered at cycle N+1; k tracks the offset from the accept cycle.
  task automatic wait_done(input string tag, input int lat, input logic [31:0] exp, input bit poke);
    int k;
    int busy_n;
    int stall_n;
    k = 1; busy_n = 0; stall_n = 0;
    while (!bus.done && k < 100) begin
      if (bus.busy)  busy_n++;
      if (bus.stall) stall_n++;
      if (poke && k == 5) begin
        bus.start = 1'b1; bus.func = FNC_DIVU; bus.op_a = 32'd100; bus.op_b = 32'd7;
      end
      if (poke && k == 6) bus.start = 1'b0;
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, k, lat);
    check({tag, "_busy_cycles"}, busy_n, lat - 1);
    check({tag, "_stall_cycles"}, stall_n, lat - 1);
    check({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_result"}, bus.result, exp);
  endtask

  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    @(negedge clk);
    launch(f, a, b);
    check({tag, "_stall_accept"}, {31'd0, bus.stall}, (lat == 1) ? 32'd0 : 32'd1);
    accept_edge();
    wait_done(tag, lat, exp, 1'b0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    last_res = exp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (tests %0d)", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int d_cnt;
    n_tests = 0; n_fail = 0; last_res = '0;
    rst = 1'b1;
    bus.start = 1'b0; bus.func = 3'd0; bus.op_a = '0; bus.op_b = '0; bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy",   {31'd0, bus.busy},  32'd0);
    check("rst_done",   {31'd0, bus.done},  32'd0);
    check("rst_stall",  {31'd0, bus.stall}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    rst = 1'b0;

    // Normal-path multiplies
    do_op("mul_7xm3",    FNC_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    do_op("mulhu_ff",    FNC_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    do_op("mulh_ff",     FNC_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    do_op("mulhsu_m1x2", FNC_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    do_op("mulh_min2",   FNC_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
    do_op("mulhsu_min",  FNC_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    do_op("mul_minx2",   FNC_MUL,    32'h80000000, 32'd2,        32'h00000000, 33);

    // Normal-path divides
    do_op("div_m7_2",    FNC_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    do_op("rem_m7_2",    FNC_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    do_op("div_7_m2",    FNC_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    do_op("rem_7_m2",    FNC_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, 33);
    do_op("div_min_2",   FNC_DIV,    32'h80000000, 32'd2,        32'hC0000000, 33);
    do_op("divu_min_ff", FNC_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
    do_op("remu_min_ff", FNC_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);

    // Fast paths: divide by zero and signed overflow
    do_op("divu_5_0",    FNC_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1);
    do_op("rem_5_0",     FNC_REM,    32'd5,        32'd0,        32'h00000005, 1);
    do_op("div_5_0",     FNC_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
    do_op("remu_m7_0",   FNC_REMU,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1);
    do_op("div_ovf",     FNC_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    do_op("rem_ovf",     FNC_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    // Back-to-back: second start issued during the DONE cycle of the first
    @(negedge clk);
    launch(FNC_DIVU, 32'd100, 32'd7);
    accept_edge();
    wait_done("divu_100_7", 33, 32'd14, 1'b0);
    launch(FNC_REMU, 32'd100, 32'd7);
    check("b2b_done_in_done", {31'd0, bus.done},  32'd1);
    check("b2b_stall",        {31'd0, bus.stall}, 32'd1);
    accept_edge();
    wait_done("remu_100_7", 33, 32'd2, 1'b0);
    last_res = 32'd2;

    // Flush at N+10 of a DIV
    @(negedge clk);
    launch(FNC_DIV, 32'd100, 32'd7);
    accept_edge();
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy",  {31'd0, bus.busy},  32'd0);
    check("flush_stall", {31'd0, bus.stall}, 32'd0);
    d_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) d_cnt++;
      @(negedge clk);
    end
    check("flush_no_done", d_cnt, 32'd0);
    check("flush_result",  bus.result, last_res);

    // start and flush together: not accepted
    launch(FNC_MUL, 32'd3, 32'd4);
    bus.flush = 1'b1;
    #1;
    check("sf_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("sf_busy", {31'd0, bus.busy}, 32'd0);
    d_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) d_cnt++;
      @(negedge clk);
    end
    check("sf_no_done", d_cnt, 32'd0);
    check("sf_result",  bus.result, last_res);

    // start during RUN is ignored
    @(negedge clk);
    launch(FNC_MUL, 32'd3, 32'd5);
    accept_edge();
    wait_done("run_ignore", 33, 32'd15, 1'b1);
    @(negedge clk);
    check("run_ignore_idle", {31'd0, bus.busy}, 32'd0);
    check("run_ignore_done", {31'd0, bus.done}, 32'd0);

    // Asynchronous reset mid-RUN, between edges
    @(negedge clk);
    launch(FNC_MUL, 32'd3, 32'd5);
    accept_edge();
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",   {31'd0, bus.busy},  32'd0);
    check("arst_done",   {31'd0, bus.done},  32'd0);
    check("arst_stall",  {31'd0, bus.stall}, 32'd0);
    check("arst_result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op("post_rst_mul", FNC_MUL, 32'd3, 32'd4, 32'd12, 33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
